// File: rtl/state_col_reader.sv
// state_col_reader: captures a 128-bit AES state and issues it one 32-bit column per handshake
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   load       capture request for data_in (honoured only in IDLE)
//   data_in    state to serialize, column 0 = [NCOL*32-1 -: 32]
//   key_word   round-key column XORed onto the output (only with STATE_COL_READER_KEY_XOR_EN)
//   col_ready  downstream accepts the presented column
//   col_valid  col_byte_* and col_idx are valid
//   col_byte_1..col_byte_4  column bytes, MSB-first
//   col_idx    index of the presented column
//   busy       high from capture until the last column is accepted
//   done       one-cycle pulse after the last column is accepted
// Optional feature macro: STATE_COL_READER_KEY_XOR_EN
module state_col_reader #(
    parameter int NCOL = 4,
    parameter int IDXW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [NCOL*32-1:0] data_in,
`ifdef STATE_COL_READER_KEY_XOR_EN
    input  logic [31:0]       key_word,
`endif
    input  logic              col_ready,
    output logic              col_valid,
    output logic [7:0]        col_byte_1,
    output logic [7:0]        col_byte_2,
    output logic [7:0]        col_byte_3,
    output logic [7:0]        col_byte_4,
    output logic [IDXW-1:0]   col_idx,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
    state_t state, state_nxt;
    logic [NCOL*32-1:0] shadow;
    logic [31:0] col_word, nxt_word, out_word;
    logic [IDXW-1:0] nxt_idx;
    logic last, xfer;
    assign last = col_idx == IDXW'(NCOL-1);
    assign xfer = state == SEND && col_ready;
    assign nxt_idx = col_idx + IDXW'(1);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    always_comb
        state_nxt = state == IDLE ? (load ? SEND : IDLE) :
                    state == SEND ? (col_ready && last ? FIN : SEND) : IDLE;
    always_comb begin
        col_valid = state == SEND;
        busy      = state == SEND;
        done      = state == FIN;
    end
    // Column that follows the presented one, preloaded so the output stays registered.
    always_comb begin
        nxt_word = '0;
        for (int i = 0; i < NCOL; i++)
            if (nxt_idx == IDXW'(i))
                nxt_word = shadow[(NCOL-1-i)*32 +: 32];
    end
    // col_word is cleared after the last column so the bytes read zero outside SEND.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            shadow   <= '0;
            col_idx  <= '0;
            col_word <= '0;
        end else if (state == IDLE && load) begin
            shadow   <= data_in;
            col_idx  <= '0;
            col_word <= data_in[NCOL*32-1 -: 32];
        end else if (xfer) begin
            col_idx  <= last ? '0 : nxt_idx;
            col_word <= last ? '0 : nxt_word;
        end
`ifdef STATE_COL_READER_KEY_XOR_EN
    assign out_word = col_valid ? col_word ^ key_word : '0;
`else
    assign out_word = col_word;
`endif
    assign {col_byte_1, col_byte_2, col_byte_3, col_byte_4} = out_word;
endmodule

// File: tb/tb_state_col_reader.sv
// tb_state_col_reader: directed checks of the column serializer
module tb_state_col_reader;
    localparam int NCOL = 4;
    localparam int IDXW = 3;
    localparam logic [127:0] D = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic clk = 0, reset = 0, load = 0, col_ready = 0;
    logic [127:0] data_in = '0;
`ifdef STATE_COL_READER_KEY_XOR_EN
    logic [31:0] key_word = 32'hA5A5A5A5;
`endif
    logic col_valid, busy, done;
    logic [7:0] col_byte_1, col_byte_2, col_byte_3, col_byte_4;
    logic [IDXW-1:0] col_idx;
    logic [31:0] cw [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    int n_cmp = 0, n_bad = 0;

    state_col_reader #(.NCOL(NCOL), .IDXW(IDXW)) dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in),
`ifdef STATE_COL_READER_KEY_XOR_EN
        .key_word(key_word),
`endif
        .col_ready(col_ready), .col_valid(col_valid),
        .col_byte_1(col_byte_1), .col_byte_2(col_byte_2),
        .col_byte_3(col_byte_3), .col_byte_4(col_byte_4),
        .col_idx(col_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(logic [31:0] w);
`ifdef STATE_COL_READER_KEY_XOR_EN
        return w ^ key_word;
`else
        return w;
`endif
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic col_chk(string tag, int idx, logic [31:0] w);
        chk({tag, ".valid"}, 64'(col_valid), 64'd1);
        chk({tag, ".idx"}, 64'(col_idx), 64'(idx));
        chk({tag, ".bytes"}, 64'({col_byte_1, col_byte_2, col_byte_3, col_byte_4}), 64'(exp_word(w)));
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".done"}, 64'(done), 64'd0);
    endtask

    task automatic idle_chk(string tag, logic exp_done);
        chk({tag, ".valid"}, 64'(col_valid), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'(exp_done));
        chk({tag, ".idx"}, 64'(col_idx), 64'd0);
        chk({tag, ".bytes"}, 64'({col_byte_1, col_byte_2, col_byte_3, col_byte_4}), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        idle_chk("rst", 1'b0);
        reset = 1;
        repeat (3) @(negedge clk);
        idle_chk("idle", 1'b0);
        // streaming with col_ready held high
        load = 1; data_in = D; col_ready = 1;
        @(negedge clk);
        load = 0; data_in = '0;
        for (int i = 0; i < NCOL; i++) begin
            col_chk($sformatf("str%0d", i), i, cw[i]);
            @(negedge clk);
        end
        idle_chk("str_fin", 1'b1);
        // a load during FIN must be dropped
        load = 1; data_in = D;
        @(negedge clk);
        load = 0;
        idle_chk("fin_load", 1'b0);
        // backpressure on column 1
        load = 1; data_in = D;
        @(negedge clk);
        load = 0;
        col_chk("bp0", 0, cw[0]);
        @(negedge clk);
        col_ready = 0;
        for (int i = 0; i < 3; i++) begin
            col_chk($sformatf("bp_hold%0d", i), 1, cw[1]);
            @(negedge clk);
        end
        col_ready = 1;
        for (int i = 1; i < NCOL; i++) begin
            col_chk($sformatf("bp%0d", i), i, cw[i]);
            @(negedge clk);
        end
        idle_chk("bp_fin", 1'b1);
        @(negedge clk);
        // load during SEND is ignored
        load = 1; data_in = D;
        @(negedge clk);
        load = 0;
        col_chk("li0", 0, cw[0]);
        @(negedge clk);
        load = 1; data_in = '1;
        col_chk("li1", 1, cw[1]);
        @(negedge clk);
        load = 0;
        col_chk("li2", 2, cw[2]);
        @(negedge clk);
        col_chk("li3", 3, cw[3]);
        @(negedge clk);
        idle_chk("li_fin", 1'b1);
        @(negedge clk);
        // reset mid-transfer after column 1 is accepted
        load = 1; data_in = D;
        @(negedge clk);
        load = 0;
        col_chk("mr0", 0, cw[0]);
        @(negedge clk);
        col_chk("mr1", 1, cw[1]);
        @(negedge clk);
        reset = 0;
        #1 idle_chk("mr_async", 1'b0);
        @(negedge clk);
        idle_chk("mr_hold", 1'b0);
        reset = 1;
        @(negedge clk);
        load = 1; data_in = D;
        @(negedge clk);
        load = 0;
        col_chk("fresh0", 0, cw[0]);
        @(negedge clk);
        col_chk("fresh1", 1, cw[1]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
